// File: rtl/cdm_err_pipe_if.sv
// Operand/result handshake bundle for cdm_err_pipe.
//   master : drives operands (in_valid, a, b) and result acceptance (out_ready)
//   slave  : the multiplier; drives in_ready, out_valid and the three result words
interface cdm_err_pipe_if #(
    parameter int W = 16
);
    logic             in_valid;
    logic             in_ready;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             out_valid;
    logic             out_ready;
    logic [2*W-1:0]   r_approx;
    logic [2*W-1:0]   r_exact;
    logic [2*W-1:0]   r_err;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, r_approx, r_exact, r_err
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, r_approx, r_exact, r_err
    );
endinterface

// File: rtl/cdm_err_pipe.sv
// Pipelined carry-disregard approximate multiplier with an exact reference
// product and running error statistics.
//
// Ports
//   clk, rst        : clock, asynchronous active-high reset
//   bus (slave)     : operand stream (in_valid/in_ready, a, b) and result stream
//                     (out_valid/out_ready, r_approx, r_exact, r_err)
//   clear_i         : synchronous clear of the statistics
//   sample_cnt_o    : consumed results (saturating)
//   err_cnt_o       : consumed results with nonzero error (saturating)
//   err_max_o       : largest consumed error
//   err_sum_o       : sum of consumed errors (saturating)
//
// Parameters: W operand width, K low columns computed carry-disregard
// (0..2W), CW counter width, SW error-sum width.
module cdm_err_pipe #(
    parameter int W  = 16,
    parameter int K  = 8,
    parameter int CW = 32,
    parameter int SW = 48
) (
    input  logic                 clk,
    input  logic                 rst,
    cdm_err_pipe_if.slave        bus,
    input  logic                 clear_i,
    output logic [CW-1:0]        sample_cnt_o,
    output logic [CW-1:0]        err_cnt_o,
    output logic [2*W-1:0]       err_max_o,
    output logic [SW-1:0]        err_sum_o
);
    localparam int PW = 2 * W;
    // Sum width wide enough to hold either operand plus a carry bit.
    localparam int XW = ((SW > PW) ? SW : PW) + 1;

    function automatic logic [PW-1:0] low_mask_f(input int k);
        logic [PW-1:0] m;
        m = '0;
        for (int c = 0; c < PW; c++) begin
            m[c] = (c < k);
        end
        return m;
    endfunction

    localparam logic [PW-1:0] LO_MASK = low_mask_f(K);
    localparam logic [SW-1:0] SUM_MAX = {SW{1'b1}};

    // Pipeline registers
    logic          en;
    logic          s1_valid_q;
    logic [W-1:0]  a_q, b_q;
    logic          out_valid_q;
    logic [PW-1:0] approx_q, exact_q, err_q;
    logic [PW-1:0] approx_d, exact_d, err_d;

    // Statistics registers
    logic [CW-1:0] sample_cnt_q, sample_cnt_d;
    logic [CW-1:0] err_cnt_q, err_cnt_d;
    logic [PW-1:0] err_max_q, err_max_d;
    logic [SW-1:0] err_sum_q, err_sum_d;
    logic [XW-1:0] sum_ext;
    logic          hs;

    // Multiplier datapath scratch
    logic [PW-1:0] row;
    logic [PW-1:0] hi_sum;
    logic [PW-1:0] lo_par;

    assign en           = !out_valid_q || bus.out_ready;
    assign hs           = out_valid_q && bus.out_ready;

    assign bus.in_ready  = en;
    assign bus.out_valid = out_valid_q;
    assign bus.r_approx  = approx_q;
    assign bus.r_exact   = exact_q;
    assign bus.r_err     = err_q;

    assign sample_cnt_o = sample_cnt_q;
    assign err_cnt_o    = err_cnt_q;
    assign err_max_o    = err_max_q;
    assign err_sum_o    = err_sum_q;

    // Each multiplier row is split by column: high columns are added exactly,
    // low columns are XOR-reduced. Since the masked high sum has all low bits
    // zero, merging the parity bits is a plain OR with no carry interaction.
    always_comb begin
        row    = '0;
        hi_sum = '0;
        lo_par = '0;
        for (int i = 0; i < W; i++) begin
            row    = a_q[i] ? (PW'(b_q) << i) : '0;
            hi_sum = hi_sum + (row & ~LO_MASK);
            lo_par = lo_par ^ (row & LO_MASK);
        end
        approx_d = hi_sum | lo_par;
        exact_d  = PW'(a_q) * PW'(b_q);
        // Dropping carries can only lose value, so this never underflows.
        err_d    = exact_d - approx_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            s1_valid_q  <= 1'b0;
            a_q         <= '0;
            b_q         <= '0;
            out_valid_q <= 1'b0;
            approx_q    <= '0;
            exact_q     <= '0;
            err_q       <= '0;
        end else if (en) begin
            s1_valid_q  <= bus.in_valid;
            out_valid_q <= s1_valid_q;
            if (bus.in_valid) begin
                a_q <= bus.a;
                b_q <= bus.b;
            end
            if (s1_valid_q) begin
                approx_q <= approx_d;
                exact_q  <= exact_d;
                err_q    <= err_d;
            end
        end
    end

    always_comb begin
        sample_cnt_d = sample_cnt_q;
        err_cnt_d    = err_cnt_q;
        err_max_d    = err_max_q;
        err_sum_d    = err_sum_q;
        sum_ext      = XW'(err_sum_q) + XW'(err_q);
        if (clear_i) begin
            // Clear beats a coincident handshake; that sample is dropped.
            sample_cnt_d = '0;
            err_cnt_d    = '0;
            err_max_d    = '0;
            err_sum_d    = '0;
        end else if (hs) begin
            if (sample_cnt_q != {CW{1'b1}}) begin
                sample_cnt_d = sample_cnt_q + CW'(1);
            end
            if ((err_q != '0) && (err_cnt_q != {CW{1'b1}})) begin
                err_cnt_d = err_cnt_q + CW'(1);
            end
            if (err_q > err_max_q) begin
                err_max_d = err_q;
            end
            if (sum_ext > XW'(SUM_MAX)) begin
                err_sum_d = SUM_MAX;
            end else begin
                err_sum_d = SW'(sum_ext);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sample_cnt_q <= '0;
            err_cnt_q    <= '0;
            err_max_q    <= '0;
            err_sum_q    <= '0;
        end else begin
            sample_cnt_q <= sample_cnt_d;
            err_cnt_q    <= err_cnt_d;
            err_max_q    <= err_max_d;
            err_sum_q    <= err_sum_d;
        end
    end

endmodule

// File: tb/tb_cdm_err_pipe.sv
// Scoreboard bench for cdm_err_pipe: main instance (K=8), an exact instance
// (K=0) and a narrow-counter instance (CW=4) for saturation.
module tb_cdm_err_pipe;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    cdm_err_pipe_if #(.W(16)) m_if ();
    cdm_err_pipe_if #(.W(16)) z_if ();
    cdm_err_pipe_if #(.W(16)) s_if ();

    logic        clr_m, clr_z, clr_s;
    logic [31:0] samp_m, errc_m, emax_m;
    logic [47:0] esum_m;
    logic [31:0] samp_z, errc_z, emax_z;
    logic [47:0] esum_z;
    logic [3:0]  samp_s, errc_s;
    logic [31:0] emax_s;
    logic [47:0] esum_s;

    cdm_err_pipe #(.W(16), .K(8), .CW(32), .SW(48)) u_main (
        .clk(clk), .rst(rst), .bus(m_if.slave), .clear_i(clr_m),
        .sample_cnt_o(samp_m), .err_cnt_o(errc_m), .err_max_o(emax_m), .err_sum_o(esum_m)
    );

    cdm_err_pipe #(.W(16), .K(0), .CW(32), .SW(48)) u_exact (
        .clk(clk), .rst(rst), .bus(z_if.slave), .clear_i(clr_z),
        .sample_cnt_o(samp_z), .err_cnt_o(errc_z), .err_max_o(emax_z), .err_sum_o(esum_z)
    );

    cdm_err_pipe #(.W(16), .K(8), .CW(4), .SW(48)) u_sat (
        .clk(clk), .rst(rst), .bus(s_if.slave), .clear_i(clr_s),
        .sample_cnt_o(samp_s), .err_cnt_o(errc_s), .err_max_o(emax_s), .err_sum_o(esum_s)
    );

    typedef struct {
        logic [31:0] ap;
        logic [31:0] ex;
        logic [31:0] er;
    } exp_t;

    exp_t sb[$];
    exp_t e;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // Monitor: pops one expectation per output handshake on the main instance.
    always @(negedge clk) begin
        if (!rst && m_if.out_valid && m_if.out_ready) begin
            if (sb.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_output: got r_exact=0x%0h expected no output", m_if.r_exact);
            end else begin
                e = sb.pop_front();
                check("r_approx", 64'(m_if.r_approx), 64'(e.ap));
                check("r_exact",  64'(m_if.r_exact),  64'(e.ex));
                check("r_err",    64'(m_if.r_err),    64'(e.er));
            end
        end
    end

    task automatic send(input logic [15:0] a, input logic [15:0] b,
                        input logic [31:0] ap, input logic [31:0] ex);
        bit done;
        done = 1'b0;
        m_if.in_valid = 1'b1;
        m_if.a = a;
        m_if.b = b;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clk);
            if (m_if.in_ready) begin
                sb.push_back(exp_t'{ap, ex, ex - ap});
                done = 1'b1;
                @(posedge clk);
                #1;
            end
        end
        m_if.in_valid = 1'b0;
        if (!done) begin
            n_checks++;
            $display("FAIL send_timeout: got in_ready=0 for 100 cycles expected acceptance a=0x%0h", a);
        end
    endtask

    task automatic drain();
        for (int i = 0; i < 60 && sb.size() != 0; i++) @(posedge clk);
        if (sb.size() != 0) begin
            n_checks++;
            $display("FAIL drain_timeout: got %0d pending expected 0", sb.size());
            sb.delete();
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    task automatic check_stats(input logic [31:0] s, input logic [31:0] c,
                               input logic [31:0] mx, input logic [47:0] sm);
        check("sample_cnt", 64'(samp_m), 64'(s));
        check("err_cnt",    64'(errc_m), 64'(c));
        check("err_max",    64'(emax_m), 64'(mx));
        check("err_sum",    64'(esum_m), 64'(sm));
    endtask

    task automatic z_run(input logic [15:0] a, input logic [15:0] b, input logic [31:0] ex);
        bit seen;
        seen = 1'b0;
        z_if.a = a;
        z_if.b = b;
        z_if.in_valid = 1'b1;
        @(posedge clk);
        #1;
        z_if.in_valid = 1'b0;
        for (int i = 0; i < 10 && !seen; i++) begin
            if (z_if.out_valid) seen = 1'b1;
            else begin
                @(posedge clk);
                #1;
            end
        end
        if (!seen) begin
            n_checks++;
            $display("FAIL k0_timeout: got out_valid=0 expected a result");
        end else begin
            check("k0_r_approx", 64'(z_if.r_approx), 64'(ex));
            check("k0_r_exact",  64'(z_if.r_exact),  64'(ex));
            check("k0_r_err",    64'(z_if.r_err),    64'h0);
        end
        repeat (2) @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got no finish expected finish before time limit");
        $fatal(1);
    end

    initial begin
        int acc;
        rst = 1'b1;
        clr_m = 1'b0; clr_z = 1'b0; clr_s = 1'b0;
        m_if.in_valid = 1'b0; m_if.a = '0; m_if.b = '0; m_if.out_ready = 1'b1;
        z_if.in_valid = 1'b0; z_if.a = '0; z_if.b = '0; z_if.out_ready = 1'b1;
        s_if.in_valid = 1'b0; s_if.a = '0; s_if.b = '0; s_if.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(posedge clk);
        #1;

        // Reset state
        check("rst_in_ready",  64'(m_if.in_ready),  64'h1);
        check("rst_out_valid", 64'(m_if.out_valid), 64'h0);
        check("rst_r_approx",  64'(m_if.r_approx),  64'h0);
        check("rst_r_exact",   64'(m_if.r_exact),   64'h0);
        check("rst_r_err",     64'(m_if.r_err),     64'h0);
        check_stats(0, 0, 0, 0);

        // First result and latency
        send(16'h00FF, 16'h00FF, 32'hF755, 32'hFE01);
        check("latency_edge_n",  64'(m_if.out_valid), 64'h0);
        @(posedge clk);
        #1;
        check("latency_edge_n1", 64'(m_if.out_valid), 64'h1);
        drain();
        check_stats(1, 1, 1708, 1708);

        // Zero-error vector
        send(16'h0001, 16'hBEEF, 32'hBEEF, 32'hBEEF);
        drain();
        check_stats(2, 1, 1708, 1708);

        // Back-to-back mixed vectors
        send(16'h0003, 16'h0003, 32'h5,       32'h9);
        send(16'h000F, 16'h000F, 32'h55,      32'hE1);
        send(16'hFFFF, 16'h0100, 32'hFFFF00,  32'hFFFF00);
        send(16'h0100, 16'h0100, 32'h10000,   32'h10000);
        drain();
        check_stats(6, 3, 1708, 1852);

        // Clear on its own
        clr_m = 1'b1;
        @(posedge clk);
        #1 clr_m = 1'b0;
        check_stats(0, 0, 0, 0);

        // Backpressure: three operands offered, consumer stalled five cycles
        m_if.out_ready = 1'b0;
        fork
            begin
                send(16'h0003, 16'h0003, 32'h5,    32'h9);
                send(16'h0001, 16'hBEEF, 32'hBEEF, 32'hBEEF);
                send(16'h00FF, 16'h00FF, 32'hF755, 32'hFE01);
            end
            begin
                repeat (2) @(posedge clk);
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    check("bp_in_ready",  64'(m_if.in_ready),  64'h0);
                    check("bp_out_valid", 64'(m_if.out_valid), 64'h1);
                    check("bp_r_approx",  64'(m_if.r_approx),  64'h5);
                    check("bp_r_exact",   64'(m_if.r_exact),   64'h9);
                end
                @(posedge clk);
                #1 m_if.out_ready = 1'b1;
            end
        join
        drain();
        check_stats(3, 2, 1708, 1712);

        // Clear coincident with a handshake
        send(16'h00FF, 16'h00FF, 32'hF755, 32'hFE01);
        @(posedge clk);
        #1 clr_m = 1'b1;
        @(posedge clk);
        #1 clr_m = 1'b0;
        drain();
        check_stats(0, 0, 0, 0);
        send(16'h0001, 16'hBEEF, 32'hBEEF, 32'hBEEF);
        drain();
        check_stats(1, 0, 0, 0);

        // Reset with two operands in flight
        send(16'h0003, 16'h0003, 32'h5,  32'h9);
        send(16'h000F, 16'h000F, 32'h55, 32'hE1);
        rst = 1'b1;
        sb.delete();
        #1;
        check("midrst_out_valid", 64'(m_if.out_valid), 64'h0);
        check("midrst_in_ready",  64'(m_if.in_ready),  64'h1);
        check("midrst_r_exact",   64'(m_if.r_exact),   64'h0);
        check_stats(0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        check("midrst_no_stale", 64'(m_if.out_valid), 64'h0);

        // Exact instance (K=0)
        z_run(16'hFFFF, 16'hFFFF, 32'hFFFE0001);
        z_run(16'h00FF, 16'h00FF, 32'h0000FE01);

        // Saturation instance (CW=4): 20 results of 0xFF*0xFF
        acc = 0;
        s_if.a = 16'h00FF;
        s_if.b = 16'h00FF;
        s_if.in_valid = 1'b1;
        for (int i = 0; i < 200 && acc < 20; i++) begin
            @(negedge clk);
            if (s_if.in_ready) acc++;
            @(posedge clk);
            #1;
        end
        s_if.in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        check("sat_sample_cnt", 64'(samp_s), 64'd15);
        check("sat_err_cnt",    64'(errc_s), 64'd15);
        check("sat_err_max",    64'(emax_s), 64'd1708);
        check("sat_err_sum",    64'(esum_s), 64'd34160);

        check("sb_leftover", 64'(sb.size()), 64'h0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
